alu_ctrl_seq: RTL and testbench

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_seq.sv | 126 ++++++++++++
 tb/tb_alu_ctrl_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq : ALU control decode plus multi-cycle mul/div launch sequencer
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu_ctrl_seq #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  logic       flush,
  input  logic [1:0] ALUOp,
  input  logic [6:0] fun7,
  input  logic [2:0] fun3,
  output logic [3:0] control_out,
  output logic       md_start,
  output logic [2:0] md_op,
  output logic       stall,
  output logic       md_done
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_MUL  = 2'd1;
  localparam logic [1:0] c_DIV  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [CNT_W-1:0] c_MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] c_DIV_LOAD = CNT_W'(DIV_LAT - 1);

  localparam logic [3:0] c_AND  = 4'b0000;
  localparam logic [3:0] c_OR   = 4'b0001;
  localparam logic [3:0] c_ADD  = 4'b0010;
  localparam logic [3:0] c_XOR  = 4'b0011;
  localparam logic [3:0] c_SLL  = 4'b0100;
  localparam logic [3:0] c_SRL  = 4'b0101;
  localparam logic [3:0] c_SUB  = 4'b0110;
  localparam logic [3:0] c_SRA  = 4'b0111;
  localparam logic [3:0] c_SLT  = 4'b1000;
  localparam logic [3:0] c_SLTU = 4'b1001;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       md_op_q, md_op_d;

  logic w_is_mop;
  logic w_idle_mop;
  logic w_accept;

  assign w_is_mop   = (ALUOp == 2'b10) && (fun7 == 7'b0000001);
  assign w_idle_mop = (state_q == c_IDLE) && valid_in && w_is_mop;
  assign w_accept   = w_idle_mop && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_IDLE;
      cnt_q   <= '0;
      md_op_q <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_op_q <= md_op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_op_d = md_op_q;
    case (state_q)
      c_IDLE: begin
        if (w_accept) begin
          md_op_d = fun3;
          if (fun3[2]) begin
            state_d = c_DIV;
            cnt_d   = c_DIV_LOAD;
          end else begin
            state_d = c_MUL;
            cnt_d   = c_MUL_LOAD;
          end
        end
      end
      c_MUL, c_DIV: begin
        // flush outranks the terminal count so an aborted op never reports done
        if (flush) begin
          state_d = c_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = c_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    control_out = c_ADD;
    if (ALUOp == 2'b01) begin
      control_out = c_SUB;
    end else if (ALUOp[1] && !w_is_mop) begin
      case (fun3)
        3'b000:  control_out = (ALUOp == 2'b10 && fun7 == 7'b0100000) ? c_SUB : c_ADD;
        3'b001:  control_out = c_SLL;
        3'b010:  control_out = c_SLT;
        3'b011:  control_out = c_SLTU;
        3'b100:  control_out = c_XOR;
        3'b101:  control_out = fun7[5] ? c_SRA : c_SRL;
        3'b110:  control_out = c_OR;
        default: control_out = c_AND;
      endcase
    end
    md_start = !reset && w_accept;
    stall    = !reset && (w_idle_mop || state_q == c_MUL || state_q == c_DIV);
    md_done  = !reset && (state_q == c_DONE);
  end

  assign md_op = md_op_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_seq : directed and randomized checks against a timestamp model
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_ctrl_seq;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  logic       clk;
  logic       reset;
  logic       valid_in;
  logic       flush;
  logic [1:0] ALUOp;
  logic [6:0] fun7;
  logic [2:0] fun3;
  logic [3:0] control_out;
  logic       md_start;
  logic [2:0] md_op;
  logic       stall;
  logic       md_done;

  alu_ctrl_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) u_dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush),
    .ALUOp(ALUOp), .fun7(fun7), .fun3(fun3), .control_out(control_out),
    .md_start(md_start), .md_op(md_op), .stall(stall), .md_done(md_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model: one outstanding op described by its acceptance cycle and latency
  bit         m_active = 1'b0;
  int         m_acc    = 0;
  int         m_lat    = 0;
  logic [2:0] m_op     = 3'b000;
  int         cyc      = 0;

  int n_done_seen  = 0;
  int n_start_seen = 0;
  int last_start   = -100;
  int last_done    = -100;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [6:0] f7,
                                          input logic [2:0] f3);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b10 && f7 == 7'h01) return 4'b0010;
    case (f3)
      3'd0: return (op == 2'b10 && f7 == 7'h20) ? 4'b0110 : 4'b0010;
      3'd1: return 4'b0100;
      3'd2: return 4'b1000;
      3'd3: return 4'b1001;
      3'd4: return 4'b0011;
      3'd5: return f7[5] ? 4'b0111 : 4'b0101;
      3'd6: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic step(input bit r, input bit v, input bit f, input logic [1:0] op,
                      input logic [6:0] f7, input logic [2:0] f3);
    bit idle, busy, done, mop, e_start, e_stall, e_done;
    idle = !m_active || (cyc > m_acc + m_lat + 1);
    busy = m_active && (cyc > m_acc) && (cyc <= m_acc + m_lat);
    done = m_active && (cyc == m_acc + m_lat + 1);
    if (done) f = 1'b0;
    mop     = (op == 2'b10) && (f7 == 7'h01);
    e_start = !r && idle && v && mop && !f;
    e_stall = !r && ((idle && v && mop) || busy);
    e_done  = !r && done;

    @(negedge clk);
    reset = r; valid_in = v; flush = f; ALUOp = op; fun7 = f7; fun3 = f3;
    #1;
    chk("control_out", 32'(control_out), 32'(ref_ctrl(op, f7, f3)));
    chk("md_start", 32'(md_start), 32'(e_start));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("md_done", 32'(md_done), 32'(e_done));
    chk("md_op", 32'(md_op), 32'(m_op));
    if (md_done) begin n_done_seen++; last_done = cyc; end
    if (md_start) begin n_start_seen++; last_start = cyc; end

    if (r) begin
      m_active = 1'b0;
      m_op     = 3'b000;
    end else if (f && busy) begin
      m_active = 1'b0;
    end else if (e_start) begin
      m_active = 1'b1;
      m_acc    = cyc;
      m_lat    = f3[2] ? DIV_LAT : MUL_LAT;
      m_op     = f3;
    end else if (idle) begin
      m_active = 1'b0;
    end
    cyc++;
  endtask

  initial begin
    int d0, s0, t0;
    reset = 1'b1; valid_in = 1'b0; flush = 1'b0; ALUOp = 2'b00; fun7 = '0; fun3 = '0;
    repeat (2) @(posedge clk);

    // reset state with an idle bus
    step(0, 0, 0, 2'b00, 7'h00, 3'd0);

    // decode corners
    step(0, 1, 0, 2'b10, 7'h20, 3'd0);
    chk("dec_sub", 32'(control_out), 32'h6);
    step(0, 1, 0, 2'b10, 7'h20, 3'd5);
    chk("dec_sra", 32'(control_out), 32'h7);
    step(0, 1, 0, 2'b11, 7'h00, 3'd7);
    chk("dec_and", 32'(control_out), 32'h0);
    step(0, 1, 0, 2'b01, 7'h00, 3'd0);
    chk("dec_br", 32'(control_out), 32'h6);

    // MUL latency
    d0 = n_done_seen;
    s0 = cyc;
    step(0, 1, 0, 2'b10, 7'h01, 3'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 2'b00, 7'h00, 3'd0);
    chk("mul_lat", 32'(last_done - s0), 32'd3);
    chk("mul_ndone", 32'(n_done_seen - d0), 32'd1);

    // DIVU with the instruction held through DONE
    d0 = n_done_seen;
    t0 = n_start_seen;
    s0 = cyc;
    for (int i = 0; i < 35; i++) step(0, 1, 0, 2'b10, 7'h01, 3'd5);
    chk("div_lat", 32'(last_done - s0), 32'd34);
    chk("div_ndone", 32'(n_done_seen - d0), 32'd1);
    chk("div_nstart", 32'(n_start_seen - t0), 32'd1);
    chk("div_op", 32'(md_op), 32'h5);
    step(0, 0, 0, 2'b00, 7'h00, 3'd0);

    // flush at cycle 10 of a DIV
    d0 = n_done_seen;
    step(0, 1, 0, 2'b10, 7'h01, 3'd4);
    for (int i = 1; i < 10; i++) step(0, 0, 0, 2'b00, 7'h00, 3'd0);
    step(0, 0, 1, 2'b00, 7'h00, 3'd0);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 2'b00, 7'h00, 3'd0);
    chk("flush_nodone", 32'(n_done_seen - d0), 32'd0);

    // flush in IDLE suppresses launch
    step(0, 1, 1, 2'b10, 7'h01, 3'd1);
    step(0, 0, 0, 2'b00, 7'h00, 3'd0);

    // reset mid-op, then a plain ADD
    step(0, 1, 0, 2'b10, 7'h01, 3'd6);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 2'b00, 7'h00, 3'd0);
    step(1, 1, 1, 2'b10, 7'h01, 3'd6);
    step(0, 1, 0, 2'b10, 7'h00, 3'd0);
    chk("rst_op", 32'(md_op), 32'h0);

    // back-to-back MULs with valid held
    for (int i = 0; i < 6; i++) step(0, 1, 0, 2'b10, 7'h01, 3'd1);
    chk("b2b", 32'(last_start - last_done), 32'd1);
    step(0, 0, 0, 2'b00, 7'h00, 3'd0);
    step(0, 0, 0, 2'b00, 7'h00, 3'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0: f7 = 7'h01;
        1: f7 = 7'h20;
        2: f7 = 7'($urandom);
        default: f7 = 7'h00;
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 49) == 0, 2'($urandom), f7, 3'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
